// File: rtl/matmul_job_controller_if.sv
// Bundle of the job, source-memory, multiplier and result-memory signals of the
// matmul job controller. The controller side is "master", its environment "slave".
interface matmul_job_controller_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int N_LEN  = $clog2(N)
) ();
  logic                 job_valid;
  logic                 job_ready;
  logic [N_LEN*2:0]     src_addr;
  logic                 src_rd;
  logic [DATA_W-1:0]    src_data;
  logic [DATA_W-1:0]    mul_a_in;
  logic [DATA_W-1:0]    mul_b_in;
  logic [N_LEN-1:0]     mul_a_i;
  logic [N_LEN-1:0]     mul_a_j;
  logic [N_LEN-1:0]     mul_b_i;
  logic [N_LEN-1:0]     mul_b_j;
  logic                 mul_a_we;
  logic                 mul_b_we;
  logic                 mul_start;
  logic                 mul_done;
  logic [N_LEN-1:0]     mul_z_i;
  logic [N_LEN-1:0]     mul_z_j;
  logic [DATA_W-1:0]    mul_z_out;
  logic                 res_we;
  logic [N_LEN*2-1:0]   res_addr;
  logic [DATA_W-1:0]    res_data;
  logic                 busy;
  logic                 job_done;
  logic                 job_err;

  modport master (
    input  job_valid, src_data, mul_done, mul_z_out,
    output job_ready, src_addr, src_rd, mul_a_in, mul_b_in,
           mul_a_i, mul_a_j, mul_b_i, mul_b_j, mul_a_we, mul_b_we,
           mul_start, mul_z_i, mul_z_j, res_we, res_addr, res_data,
           busy, job_done, job_err
  );

  modport slave (
    output job_valid, src_data, mul_done, mul_z_out,
    input  job_ready, src_addr, src_rd, mul_a_in, mul_b_in,
           mul_a_i, mul_a_j, mul_b_i, mul_b_j, mul_a_we, mul_b_we,
           mul_start, mul_z_i, mul_z_j, res_we, res_addr, res_data,
           busy, job_done, job_err
  );
endinterface

// File: rtl/matmul_job_controller.sv
// Job sequencer for the parallel NxN multiplier: loads A then B from the source
// memory, starts the multiply, waits with a watchdog, then drains the results.
module matmul_job_controller #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int N_LEN   = $clog2(N),
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  matmul_job_controller_if.master bus
);
  localparam int NN     = N * N;
  localparam int AW     = 2 * N_LEN;
  localparam int KW     = AW + 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0]   LOAD_LAST  = KW'(2 * NN - 1);
  localparam logic [AW-1:0]   DRAIN_LAST = AW'(NN - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_r;
  logic              job_ready_r;
  logic              busy_r;
  logic              src_rd_r;
  logic [KW-1:0]     src_addr_r;
  logic              a_we_r;
  logic              b_we_r;
  logic [N_LEN-1:0]  a_i_r;
  logic [N_LEN-1:0]  a_j_r;
  logic [N_LEN-1:0]  b_i_r;
  logic [N_LEN-1:0]  b_j_r;
  logic              mul_start_r;
  logic [WD_W-1:0]   wd_r;
  logic [N_LEN-1:0]  z_i_r;
  logic [N_LEN-1:0]  z_j_r;
  logic              res_we_r;
  logic [AW-1:0]     res_addr_r;
  logic              job_done_r;
  logic              job_err_r;
  logic [AW-1:0]     res_next_s;

  // Next drain index; its row/column halves are the multiplier result index.
  always_comb begin
    res_next_s = res_addr_r + 1'b1;
  end

  // Job FSM. src_addr doubles as the load counter k: its top bit selects B,
  // the remaining bits split directly into row and column.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      job_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      src_rd_r    <= 1'b0;
      src_addr_r  <= '0;
      a_we_r      <= 1'b0;
      b_we_r      <= 1'b0;
      a_i_r       <= '0;
      a_j_r       <= '0;
      b_i_r       <= '0;
      b_j_r       <= '0;
      mul_start_r <= 1'b0;
      wd_r        <= '0;
      z_i_r       <= '0;
      z_j_r       <= '0;
      res_we_r    <= 1'b0;
      res_addr_r  <= '0;
      job_done_r  <= 1'b0;
      job_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          job_err_r <= 1'b0;
          // job_ready is low during a job_err pulse, so acceptance waits a cycle
          if (job_ready_r && bus.job_valid) begin
            state_r     <= S_LOAD;
            job_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            src_rd_r    <= 1'b1;
            src_addr_r  <= '0;
          end else begin
            job_ready_r <= 1'b1;
          end
        end
        S_LOAD: begin
          a_we_r <= ~src_addr_r[AW];
          b_we_r <= src_addr_r[AW];
          if (src_addr_r[AW]) begin
            b_i_r <= src_addr_r[AW-1:N_LEN];
            b_j_r <= src_addr_r[N_LEN-1:0];
          end else begin
            a_i_r <= src_addr_r[AW-1:N_LEN];
            a_j_r <= src_addr_r[N_LEN-1:0];
          end
          if (src_addr_r == LOAD_LAST) begin
            state_r    <= S_START;
            src_rd_r   <= 1'b0;
            src_addr_r <= '0;
          end else begin
            src_addr_r <= src_addr_r + 1'b1;
          end
        end
        S_START: begin
          a_we_r      <= 1'b0;
          b_we_r      <= 1'b0;
          mul_start_r <= 1'b1;
          wd_r        <= '0;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            mul_start_r <= 1'b0;
            res_we_r    <= 1'b1;
            res_addr_r  <= '0;
            z_i_r       <= '0;
            z_j_r       <= '0;
            state_r     <= S_DRAIN;
          end else if (wd_r == WD_LAST) begin
            mul_start_r <= 1'b0;
            job_err_r   <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            wd_r <= wd_r + 1'b1;
          end
        end
        S_DRAIN: begin
          if (res_addr_r == DRAIN_LAST) begin
            res_we_r   <= 1'b0;
            res_addr_r <= '0;
            z_i_r      <= '0;
            z_j_r      <= '0;
            job_done_r <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            res_addr_r <= res_next_s;
            z_i_r      <= res_next_s[AW-1:N_LEN];
            z_j_r      <= res_next_s[N_LEN-1:0];
          end
        end
        S_DONE: begin
          job_done_r  <= 1'b0;
          busy_r      <= 1'b0;
          job_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          job_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          src_rd_r    <= 1'b0;
          a_we_r      <= 1'b0;
          b_we_r      <= 1'b0;
          mul_start_r <= 1'b0;
          res_we_r    <= 1'b0;
          job_done_r  <= 1'b0;
          job_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.job_ready = job_ready_r;
  assign bus.busy      = busy_r;
  assign bus.src_rd    = src_rd_r;
  assign bus.src_addr  = src_addr_r;
  assign bus.mul_a_we  = a_we_r;
  assign bus.mul_b_we  = b_we_r;
  assign bus.mul_a_i   = a_i_r;
  assign bus.mul_a_j   = a_j_r;
  assign bus.mul_b_i   = b_i_r;
  assign bus.mul_b_j   = b_j_r;
  // Element data is the returned read word, gated so idle ports stay at zero.
  assign bus.mul_a_in  = a_we_r ? bus.src_data : {DATA_W{1'b0}};
  assign bus.mul_b_in  = b_we_r ? bus.src_data : {DATA_W{1'b0}};
  assign bus.mul_start = mul_start_r;
  assign bus.mul_z_i   = z_i_r;
  assign bus.mul_z_j   = z_j_r;
  assign bus.res_we    = res_we_r;
  assign bus.res_addr  = res_addr_r;
  assign bus.res_data  = res_we_r ? bus.mul_z_out : {DATA_W{1'b0}};
  assign bus.job_done  = job_done_r;
  assign bus.job_err   = job_err_r;
endmodule

// File: tb/tb_matmul_job_controller.sv
// Bench for matmul_job_controller: source-memory and multiplier models, a table of
// jobs checked against a reference product, plus back-to-back and reset corner cases.
module tb_matmul_job_controller;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NL = 2;
  localparam int TO = 8;
  localparam int NN = N * N;

  typedef struct {
    bit             b;
    int             i;
    int             j;
    logic [DW-1:0]  d;
  } wr_t;

  typedef struct {
    int             addr;
    logic [DW-1:0]  d;
  } rs_t;

  typedef struct {
    int  kind;
    int  delay;
    bit  exp_err;
    int  exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  matmul_job_controller_if #(.N(N), .DATA_W(DW), .N_LEN(NL)) bus ();

  matmul_job_controller #(.N(N), .DATA_W(DW), .N_LEN(NL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src_mem [2*NN];
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [DW-1:0] z_acc;
  wr_t  wlog [$];
  rs_t  rlog [$];
  int   done_delay = 0;
  int   wait_cnt   = 0;
  int   start_cnt  = 0;
  int   rd_cnt     = 0;
  int   both_cnt   = 0;
  int   done_cnt   = 0;
  int   err_cnt    = 0;
  int   checks     = 0;
  int   failures   = 0;

  // Source memory: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.src_rd) bus.src_data <= src_mem[bus.src_addr];
  end

  // Multiplier model: raises done on the done_delay-th cycle of mul_start (0 = never).
  assign bus.mul_done = (done_delay != 0) && bus.mul_start && (wait_cnt == done_delay - 1);

  always_comb begin
    z_acc = '0;
    for (int k = 0; k < N; k++) z_acc = z_acc + ma[bus.mul_z_i][k] * mb[k][bus.mul_z_j];
  end
  assign bus.mul_z_out = z_acc;

  // Monitors: element writes, result writes and event counters.
  always @(posedge clk) begin
    wr_t w;
    rs_t r;
    if (!rst) wait_cnt <= 0;
    else if (bus.mul_start) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (rst) begin
      if (bus.mul_a_we) begin
        ma[bus.mul_a_i][bus.mul_a_j] <= bus.mul_a_in;
        w.b = 1'b0; w.i = int'(bus.mul_a_i); w.j = int'(bus.mul_a_j); w.d = bus.mul_a_in;
        wlog.push_back(w);
      end
      if (bus.mul_b_we) begin
        mb[bus.mul_b_i][bus.mul_b_j] <= bus.mul_b_in;
        w.b = 1'b1; w.i = int'(bus.mul_b_i); w.j = int'(bus.mul_b_j); w.d = bus.mul_b_in;
        wlog.push_back(w);
      end
      if (bus.res_we) begin
        r.addr = int'(bus.res_addr); r.d = bus.res_data;
        rlog.push_back(r);
      end
      if (bus.mul_a_we && bus.mul_b_we) both_cnt <= both_cnt + 1;
      if (bus.mul_start) start_cnt <= start_cnt + 1;
      if (bus.src_rd) rd_cnt <= rd_cnt + 1;
      if (bus.job_done) done_cnt <= done_cnt + 1;
      if (bus.job_err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] out_vec();
    return {bus.job_ready, bus.busy, bus.job_done, bus.job_err, bus.src_rd, bus.src_addr,
            bus.mul_a_we, bus.mul_b_we, bus.mul_a_i, bus.mul_a_j, bus.mul_b_i, bus.mul_b_j,
            bus.mul_start, bus.mul_z_i, bus.mul_z_j, bus.res_we, bus.res_addr,
            bus.res_data, bus.mul_a_in, bus.mul_b_in};
  endfunction

  function automatic logic [DW-1:0] ref_c(input int i, input int j);
    logic [DW-1:0] acc = '0;
    for (int k = 0; k < N; k++) acc = acc + src_mem[i*N + k] * src_mem[NN + k*N + j];
    return acc;
  endfunction

  task automatic fill_src(input int kind);
    for (int e = 0; e < 2*NN; e++) begin
      if (kind == 0) src_mem[e] = (e < NN) ? ((e / N == e % N) ? 32'd1 : 32'd0) : DW'(e - NN);
      else if (kind == 2) src_mem[e] = 32'hFFFF_FFFF;
      else src_mem[e] = $urandom;
    end
  endtask

  task automatic check_results(input string tag, input int r0);
    int mism = 0;
    check({tag, "_res_n"}, rlog.size() - r0, NN);
    for (int e = 0; e < NN; e++) begin
      if (r0 + e >= rlog.size()) mism++;
      else if (rlog[r0+e].addr != e || rlog[r0+e].d !== ref_c(e / N, e % N)) mism++;
    end
    check({tag, "_res_bad"}, mism, 0);
  endtask

  task automatic run_job(input string tag, input int kind, input int delay,
                         input bit exp_err, input int exp_cyc);
    int w0 = wlog.size();
    int r0 = rlog.size();
    int s0 = start_cnt, rd0 = rd_cnt, b0 = both_cnt, d0 = done_cnt, e0 = err_cnt;
    int n, mism;
    bit got_done, got_err;
    fill_src(kind);
    done_delay = delay;
    @(negedge clk);
    check({tag, "_ready0"}, bus.job_ready, 1'b1);
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    n = 1;
    while (!(bus.job_done || bus.job_err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    got_done = bus.job_done;
    got_err  = bus.job_err;
    check({tag, "_outcome"}, {got_done, got_err}, exp_err ? 2'b01 : 2'b10);
    check({tag, "_latency"}, n, exp_cyc);
    @(negedge clk);
    check({tag, "_ready_busy"}, {bus.job_ready, bus.busy}, 2'b10);
    check({tag, "_pulses"}, {done_cnt - d0, err_cnt - e0}, exp_err ? {32'd0, 32'd1} : {32'd1, 32'd0});
    check({tag, "_start_cyc"}, start_cnt - s0, exp_err ? TO : delay);
    check({tag, "_rd_cyc"}, rd_cnt - rd0, 2*NN);
    check({tag, "_both_we"}, both_cnt - b0, 0);
    mism = 0;
    for (int e = 0; e < 2*NN; e++) begin
      if (w0 + e >= wlog.size()) mism++;
      else if (wlog[w0+e].b != (e >= NN) || wlog[w0+e].i != (e % NN) / N ||
               wlog[w0+e].j != e % N || wlog[w0+e].d !== src_mem[e]) mism++;
    end
    check({tag, "_load_n"}, wlog.size() - w0, 2*NN);
    check({tag, "_load_bad"}, mism, 0);
    if (exp_err) check({tag, "_no_res"}, rlog.size() - r0, 0);
    else check_results(tag, r0);
  endtask

  vec_t vt [6];
  logic [127:0] rst_vec;

  initial begin
    int n, r0, d0, e0, seen, dly;
    rst_vec = 128'd1 << 125;
    bus.job_valid = 1'b0;
    vt[0] = '{0, 3,  1'b0, 2*NN + 1 + 3 + NN + 1};
    vt[1] = '{1, 1,  1'b0, 2*NN + 1 + 1 + NN + 1};
    vt[2] = '{1, TO, 1'b0, 2*NN + 1 + TO + NN + 1};
    vt[3] = '{1, 0,  1'b1, 2*NN + 1 + TO + 1};
    vt[4] = '{2, 7,  1'b0, 2*NN + 1 + 7 + NN + 1};
    vt[5] = '{1, 9,  1'b1, 2*NN + 1 + TO + 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), rst_vec);
    rst = 1'b1;

    for (int t = 0; t < 6; t++)
      run_job($sformatf("vec%0d", t), vt[t].kind, vt[t].delay, vt[t].exp_err, vt[t].exp_cyc);

    for (int t = 0; t < 3; t++) begin
      dly = $urandom_range(1, TO);
      run_job($sformatf("rnd%0d", t), 1, dly, 1'b0, 2*NN + 1 + dly + NN + 1);
    end

    // Back-to-back: job_valid held high across two jobs.
    fill_src(1);
    done_delay = 3;
    @(negedge clk);
    bus.job_valid = 1'b1;
    @(negedge clk);
    n = 1;
    while (!bus.job_done && n < 300) begin @(negedge clk); n++; end
    check("b2b_lat1", n, 2*NN + 1 + 3 + NN + 1);
    fill_src(1);
    done_delay = 4;
    r0 = rlog.size();
    @(negedge clk);
    check("b2b_ready", {bus.job_ready, bus.busy}, 2'b10);
    @(negedge clk);
    check("b2b_accept", {bus.job_ready, bus.busy}, 2'b01);
    n = 1;
    while (!bus.job_done && n < 300) begin @(negedge clk); n++; end
    bus.job_valid = 1'b0;
    check("b2b_lat2", n, 2*NN + 1 + 4 + NN + 1);
    @(negedge clk);
    check_results("b2b", r0);

    // Reset in the 5th DRAIN cycle, then a clean job.
    fill_src(1);
    done_delay = 2;
    @(negedge clk);
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    seen = 0;
    n = 0;
    while (seen < 5 && n < 300) begin
      if (bus.res_we) seen++;
      if (seen < 5) begin @(negedge clk); n++; end
    end
    check("rst_drain_seen", seen, 5);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", out_vec(), rst_vec);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
    run_job("after_rst", 1, 5, 1'b0, 2*NN + 1 + 5 + NN + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
